// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - APB master that shares the UART transmit path between byte requesters
// Optional macro UART_SCHED_PRIO_EN: requester 0 is high priority over the round-robin set.
module uart_tx_scheduler #(
  parameter int          NUM_REQ  = 4,
  parameter int          POLL_GAP = 16,
  parameter logic [11:0] ADDR_TDR = 12'h000,
  parameter logic [11:0] ADDR_LSR = 12'h014,
  parameter logic [11:0] ADDR_OCR = 12'h020
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [31:0]          ocr_cfg_i,
  output logic                 m_psel,
  output logic                 m_penable,
  output logic                 m_pwrite,
  output logic [11:0]          m_paddr,
  output logic [3:0]           m_pstrb,
  output logic [31:0]          m_pwdata,
  input  logic                 m_pready,
  input  logic                 m_pslverr,
  input  logic [31:0]          m_prdata,
  output logic                 busy_o,
  output logic [2:0]           grant_id_o,
  output logic                 err_o,
  input  logic                 err_clr_i
);

  typedef enum logic [2:0] {IDLE, POLL_S, POLL_A, GAP, TDR_S, TDR_A, OCR_S, OCR_A} state_t;

  state_t       r_state;
  logic [2:0]   r_rr;
  logic [2:0]   r_grant;
  logic [7:0]   r_byte;
  logic [15:0]  r_gap_cnt;
  logic         r_err;
  logic         r_psel;
  logic         r_penable;
  logic         r_pwrite;
  logic [11:0]  r_paddr;
  logic [3:0]   r_pstrb;
  logic [31:0]  r_pwdata;

  logic [NUM_REQ-1:0] w_rr_valid;
  logic [7:0]         w_valid8;
  logic [63:0]        w_data64;
  logic [2:0]         w_idx;
  logic [2:0]         w_gnt;
  logic               w_found;
  logic [7:0]         w_byte;
  logic               w_unused;

`ifdef UART_SCHED_PRIO_EN
  assign w_rr_valid = req_valid_i & ~NUM_REQ'(1);
`else
  assign w_rr_valid = req_valid_i;
`endif
  assign w_valid8 = 8'(w_rr_valid);
  assign w_data64 = 64'(req_data_i);

  // Search starts just after the last granted index and wraps modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = 3'd0;
    w_idx   = 3'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = 3'((int'(r_rr) + i) % NUM_REQ);
      if (!w_found && w_valid8[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
`ifdef UART_SCHED_PRIO_EN
    if (req_valid_i[0]) begin
      w_found = 1'b1;
      w_gnt   = 3'd0;
    end
`endif
  end

  assign w_byte      = w_data64[{w_gnt, 3'b000} +: 8];
  assign req_ready_o = (r_state == IDLE && w_found) ? (NUM_REQ'(1) << w_gnt) : '0;
  assign w_unused    = ^{m_prdata[31:5], m_prdata[3:0]};

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state   <= IDLE;
      r_rr      <= 3'(NUM_REQ - 1);
      r_grant   <= 3'd0;
      r_byte    <= 8'd0;
      r_gap_cnt <= 16'd0;
      r_err     <= 1'b0;
      {r_psel, r_penable, r_pwrite, r_paddr, r_pstrb, r_pwdata} <= '0;
    end else begin
      if (err_clr_i)
        r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_byte  <= w_byte;
            r_grant <= w_gnt;
`ifdef UART_SCHED_PRIO_EN
            if (w_gnt != 3'd0)
              r_rr <= w_gnt;
`else
            r_rr <= w_gnt;
`endif
            r_state  <= POLL_S;
            r_psel   <= 1'b1;
            r_pwrite <= 1'b0;
            r_paddr  <= ADDR_LSR;
            r_pstrb  <= 4'h0;
            r_pwdata <= 32'd0;
          end
        end
        POLL_S: begin
          r_state   <= POLL_A;
          r_penable <= 1'b1;
        end
        POLL_A: begin
          if (m_pready) begin
            if (m_pslverr) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
              {r_psel, r_penable, r_pwrite, r_paddr, r_pstrb, r_pwdata} <= '0;
            end else if (m_prdata[4]) begin
              r_state   <= TDR_S;
              r_penable <= 1'b0;
              r_pwrite  <= 1'b1;
              r_paddr   <= ADDR_TDR;
              r_pstrb   <= 4'hF;
              r_pwdata  <= {24'd0, r_byte};
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= 16'(POLL_GAP - 1);
              {r_psel, r_penable, r_pwrite, r_paddr, r_pstrb, r_pwdata} <= '0;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == 16'd0) begin
            r_state <= POLL_S;
            r_psel  <= 1'b1;
            r_paddr <= ADDR_LSR;
          end else begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
          end
        end
        TDR_S: begin
          r_state   <= TDR_A;
          r_penable <= 1'b1;
        end
        TDR_A: begin
          if (m_pready) begin
            if (m_pslverr) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
              {r_psel, r_penable, r_pwrite, r_paddr, r_pstrb, r_pwdata} <= '0;
            end else begin
              r_state   <= OCR_S;
              r_penable <= 1'b0;
              r_paddr   <= ADDR_OCR;
              r_pwdata  <= ocr_cfg_i | 32'h2;
            end
          end
        end
        OCR_S: begin
          r_state   <= OCR_A;
          r_penable <= 1'b1;
        end
        OCR_A: begin
          if (m_pready) begin
            if (m_pslverr)
              r_err <= 1'b1;
            r_state <= IDLE;
            {r_psel, r_penable, r_pwrite, r_paddr, r_pstrb, r_pwdata} <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_psel     = r_psel;
  assign m_penable  = r_penable;
  assign m_pwrite   = r_pwrite;
  assign m_paddr    = r_paddr;
  assign m_pstrb    = r_pstrb;
  assign m_pwdata   = r_pwdata;
  assign busy_o     = (r_state != IDLE);
  assign grant_id_o = r_grant;
  assign err_o      = r_err;

endmodule
